display_timings: RTL
====================

DISPLAY_TIMINGS -- requirements
Module: display_timings

Interface
REQ-001 Parameter H_RES, default 640, active pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch (pixels).
REQ-003 Parameter H_SYNC, default 96, horizontal sync width (pixels).
REQ-004 Parameter H_BP, default 48, horizontal back porch (pixels).
REQ-005 Parameter V_RES, default 480, active lines per frame.
REQ-006 Parameter V_FP, default 10, vertical front porch (lines).
REQ-007 Parameter V_SYNC, default 2, vertical sync width (lines).
REQ-008 Parameter V_BP, default 33, vertical back porch (lines).
REQ-009 Parameter H_POL, default 0, hsync active level (1 = active high).
REQ-010 Parameter V_POL, default 0, vsync active level (1 = active high).
REQ-011 i_pix_clk  input  1  pixel clock; all logic on its rising edge.
REQ-012 i_rst_n  input  1  reset, synchronous, active-low.
REQ-013 i_en  input  1  advance enable; low freezes timing.
REQ-014 o_hs  output  1  horizontal sync at polarity H_POL.
REQ-015 o_vs  output  1  vertical sync at polarity V_POL.
REQ-016 o_de  output  1  data enable, high only inside the active area.
REQ-017 o_frame  output  1  one-cycle strobe at pixel (0,0).
REQ-018 o_line  output  1  one-cycle strobe at x = 0 of every line, including blanking lines.
REQ-019 o_x  output  16  unsigned horizontal position, directly consumable as a pattern generator's i_x.
REQ-020 o_y  output  16  unsigned vertical position, directly consumable as a pattern generator's i_y.

Function
REQ-021 Derived totals: H_TOTAL = H_RES+H_FP+H_SYNC+H_BP and V_TOTAL = V_RES+V_FP+V_SYNC+V_BP; each SHALL be at most 65536, enforced by an elaboration-time check.
REQ-022 The internal counter cx SHALL step 0..H_TOTAL-1 on each i_en cycle and wrap to 0; cy SHALL increment only on cx wrap and wrap to 0 after V_TOTAL-1.
REQ-023 All outputs SHALL be registered functions of (cx,cy) with one cycle of latency: outputs at cycle n+1 reflect the counter value at cycle n.
REQ-024 Within a line, positions SHALL occur in the order active [0,H_RES-1], front porch, sync [H_RES+H_FP, H_RES+H_FP+H_SYNC-1], back porch; lines follow the same order vertically.
REQ-025 o_hs SHALL be at level H_POL while x is in the sync range and at the opposite level otherwise; o_vs SHALL follow the same rule on y with V_POL, for the whole line width.
REQ-026 o_de SHALL be (x < H_RES) AND (y < V_RES).
REQ-027 o_x and o_y SHALL keep counting through blanking, reaching H_TOTAL-1 and V_TOTAL-1 respectively.
REQ-028 o_line SHALL be 1 when x = 0; o_frame SHALL be 1 when x = 0 and y = 0; both SHALL be 0 in any cycle where i_en was low.
REQ-029 While i_en is low, cx, cy, o_x, o_y, o_hs, o_vs and o_de SHALL hold their values.
REQ-030 At the simultaneous wrap (cx = H_TOTAL-1, cy = V_TOTAL-1), the next position SHALL be (0,0) with no skipped or repeated pixel.

Reset
REQ-031 While i_rst_n is low at a clock edge: cx = cy = 0, o_x = o_y = 0, o_de = 0, o_frame = 0, o_line = 0, o_hs = !H_POL, o_vs = !V_POL.
REQ-032 On the first i_en cycle after release, the outputs SHALL present position (0,0) with o_de = o_frame = o_line = 1.
REQ-033 Reset asserted mid-frame SHALL take priority over i_en and SHALL abandon the frame; no partial sync pulse is extended.

Structure
REQ-034 Package display_timing_pkg SHALL hold the standard mode constants 640x480p60 (640/16/96/48, 480/10/2/33, negative polarity) and 1280x720p60 (1280/110/40/220, 720/5/5/20, positive polarity).
REQ-035 Sub-module display_axis_counter (parameters RES/FP/SYNC/BP/POL; ports: count, wrap, sync, active) SHALL be instantiated twice, for the horizontal and vertical axes.

Verification
REQ-036 Small mode H=8/2/3/1, V=4/1/2/1, POL=1: o_hs SHALL be high exactly at x = 10..12 (3 cycles) out of every 14, and o_x SHALL run 0..13.
REQ-037 Same mode: o_vs SHALL be high for lines y = 5..6 (28 cycles), o_de SHALL be high for 32 cycles per 112-cycle frame, and o_frame SHALL pulse every 112 cycles.
REQ-038 Toggle i_en low for 5 cycles at x = 7: the outputs SHALL hold at x = 7, o_line and o_frame SHALL stay 0, and the sequence SHALL resume at x = 8.
REQ-039 Assert reset at (x=5, y=2): the outputs SHALL show the reset values; after release the first output SHALL be (0,0) with o_frame = 1.
REQ-040 Default 640x480 mode: the frame period SHALL be 800x525 = 420000 cycles, o_hs SHALL be low at x = 656..751, and o_vs SHALL be low at y = 490..491.

Source files
------------

// File: rtl/display_timing_pkg.sv
// Shared mode constants and small helpers for the display timing generator.
// Standard modes are bundled as one struct so a mode can be selected as a unit.
package display_timing_pkg;

    localparam int COORD_W   = 16;
    localparam int MAX_TOTAL = 65536;

    typedef struct packed {
        int   h_res;
        int   h_fp;
        int   h_sync;
        int   h_bp;
        int   v_res;
        int   v_fp;
        int   v_sync;
        int   v_bp;
        logic h_pol;
        logic v_pol;
    } mode_t;

    localparam mode_t MODE_640X480P60 = '{
        h_res: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_res: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
        h_pol: 1'b0, v_pol: 1'b0
    };

    localparam mode_t MODE_1280X720P60 = '{
        h_res: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
        v_res: 720,  v_fp: 5,   v_sync: 5,  v_bp: 20,
        h_pol: 1'b1, v_pol: 1'b1
    };

    // True when pos lies in the half-open window [lo, hi).
    function automatic logic in_window(input logic [COORD_W-1:0] pos, input int lo, input int hi);
        logic [31:0] p;
        p = 32'(pos);
        return (p >= 32'(lo)) && (p < 32'(hi));
    endfunction

endpackage

// File: rtl/display_axis_counter.sv
// One timing axis: position counter with wrap, sync-at-polarity and active-area flags.
// The same block serves the horizontal (step every enabled pixel) and vertical axis.
module display_axis_counter
    import display_timing_pkg::*;
#(
    parameter int   RES  = 640,
    parameter int   FP   = 16,
    parameter int   SYNC = 96,
    parameter int   BP   = 48,
    parameter logic POL  = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               step,
    output logic [COORD_W-1:0] count,
    output logic               wrap,
    output logic               sync,
    output logic               active
);

    localparam int TOTAL      = RES + FP + SYNC + BP;
    localparam int SYNC_START = RES + FP;
    localparam int SYNC_END   = RES + FP + SYNC;
    localparam logic [COORD_W-1:0] LAST = COORD_W'(TOTAL - 1);

    // Decode position flags from the current count.
    always_comb begin
        wrap   = (count == LAST);
        sync   = in_window(count, SYNC_START, SYNC_END) ? POL : ~POL;
        active = in_window(count, 0, RES);
    end

    // Position counter: steps on enable, wraps after the last position.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= {COORD_W{1'b0}};
        end else if (step) begin
            if (wrap) begin
                count <= {COORD_W{1'b0}};
            end else begin
                count <= count + 16'd1;
            end
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/display_timings.sv
// Video timing generator: raster counters plus registered sync, data-enable,
// strobes and coordinates, all one cycle behind the internal counters.
module display_timings
    import display_timing_pkg::*;
#(
    parameter int   H_RES  = MODE_640X480P60.h_res,
    parameter int   H_FP   = MODE_640X480P60.h_fp,
    parameter int   H_SYNC = MODE_640X480P60.h_sync,
    parameter int   H_BP   = MODE_640X480P60.h_bp,
    parameter int   V_RES  = MODE_640X480P60.v_res,
    parameter int   V_FP   = MODE_640X480P60.v_fp,
    parameter int   V_SYNC = MODE_640X480P60.v_sync,
    parameter int   V_BP   = MODE_640X480P60.v_bp,
    parameter logic H_POL  = MODE_640X480P60.h_pol,
    parameter logic V_POL  = MODE_640X480P60.v_pol
) (
    input  logic               i_pix_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    output logic               o_hs,
    output logic               o_vs,
    output logic               o_de,
    output logic               o_frame,
    output logic               o_line,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y
);

    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_check
        $error("display_timings: totals %0d x %0d exceed 16-bit coordinate range", H_TOTAL, V_TOTAL);
    end

    logic [COORD_W-1:0] h_count_s;
    logic [COORD_W-1:0] v_count_s;
    logic               h_wrap_s;
    logic               v_wrap_s;
    logic               h_sync_s;
    logic               v_sync_s;
    logic               h_active_s;
    logic               v_active_s;
    logic               v_step_s;
    logic               line_start_r;
    logic               frame_start_r;

    assign v_step_s = i_en & h_wrap_s;

    display_axis_counter #(
        .RES (H_RES),
        .FP  (H_FP),
        .SYNC(H_SYNC),
        .BP  (H_BP),
        .POL (H_POL)
    ) u_h_axis (
        .clk   (i_pix_clk),
        .rst_n (i_rst_n),
        .step  (i_en),
        .count (h_count_s),
        .wrap  (h_wrap_s),
        .sync  (h_sync_s),
        .active(h_active_s)
    );

    display_axis_counter #(
        .RES (V_RES),
        .FP  (V_FP),
        .SYNC(V_SYNC),
        .BP  (V_BP),
        .POL (V_POL)
    ) u_v_axis (
        .clk   (i_pix_clk),
        .rst_n (i_rst_n),
        .step  (v_step_s),
        .count (v_count_s),
        .wrap  (v_wrap_s),
        .sync  (v_sync_s),
        .active(v_active_s)
    );

    // Track whether the counters currently sit at x = 0 / (0,0); set by wrap instead of a wide compare.
    always_ff @(posedge i_pix_clk) begin
        if (!i_rst_n) begin
            line_start_r  <= 1'b1;
            frame_start_r <= 1'b1;
        end else if (i_en) begin
            line_start_r  <= h_wrap_s;
            frame_start_r <= h_wrap_s & v_wrap_s;
        end else begin
            line_start_r  <= line_start_r;
            frame_start_r <= frame_start_r;
        end
    end

    // Output register stage; strobes are suppressed on frozen cycles while levels hold.
    always_ff @(posedge i_pix_clk) begin
        if (!i_rst_n) begin
            o_x     <= {COORD_W{1'b0}};
            o_y     <= {COORD_W{1'b0}};
            o_hs    <= ~H_POL;
            o_vs    <= ~V_POL;
            o_de    <= 1'b0;
            o_frame <= 1'b0;
            o_line  <= 1'b0;
        end else if (i_en) begin
            o_x     <= h_count_s;
            o_y     <= v_count_s;
            o_hs    <= h_sync_s;
            o_vs    <= v_sync_s;
            o_de    <= h_active_s & v_active_s;
            o_frame <= frame_start_r;
            o_line  <= line_start_r;
        end else begin
            o_x     <= o_x;
            o_y     <= o_y;
            o_hs    <= o_hs;
            o_vs    <= o_vs;
            o_de    <= o_de;
            o_frame <= 1'b0;
            o_line  <= 1'b0;
        end
    end

endmodule
